// File: rtl/als_sequencer.sv
// ---------------------------------------------------------------------------
// als_sequencer
// Sequences one request at a time through an external ALU, a three-step
// shifter (load / execute / capture) or a multi-cycle multiplier, and
// returns a one-cycle response pulse with the result.
//
// Parameters
//   MULT_STATE    workMult code driven on mult_state while a multiply runs
//   MULT_TIMEOUT  maximum number of cycles to wait for mult_end
//
// Optional feature (compile-time macro)
//   ALS_SEQ_OVF_TRAP_EN  when defined, an ALU overflow turns the response
//                        into an error with zero data
//
// Ports
//   Clk, reset                         clock, synchronous active-high reset
//   req_valid/req_ready                request handshake
//   req_kind, req_fn, req_shamt        request kind, function, shift amount
//   req_a, req_b                       operands
//   alu_sel, oper_a, oper_b            ALU controls / operands
//   alu_result, alu_overflow           ALU results
//   shift_reset, shift_op, shift_n,    shifter controls / operand
//   shift_in, shift_out                shifter result
//   mult_state, mult_end, mult_prod    multiplier control / completion
//   rsp_valid, rsp_lo, rsp_hi,         response pulse and held result
//   rsp_err, busy                      error flag, busy status
// ---------------------------------------------------------------------------
module als_sequencer #(
    parameter logic [5:0]  MULT_STATE   = 6'd1,
    parameter int unsigned MULT_TIMEOUT = 40
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [2:0]  req_fn,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [2:0]  alu_sel,
    output logic [31:0] oper_a,
    output logic [31:0] oper_b,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        shift_reset,
    output logic [2:0]  shift_op,
    output logic [4:0]  shift_n,
    output logic [31:0] shift_in,
    input  logic [31:0] shift_out,
    output logic [5:0]  mult_state,
    input  logic        mult_end,
    input  logic [63:0] mult_prod,
    output logic        rsp_valid,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned CNT_W = (MULT_TIMEOUT < 1) ? 1 : $clog2(MULT_TIMEOUT + 1);

    localparam logic [1:0] KIND_ALU   = 2'b00;
    localparam logic [1:0] KIND_SHIFT = 2'b01;
    localparam logic [1:0] KIND_MUL   = 2'b10;

    localparam logic [2:0] SH_OP_NOP  = 3'b000;
    localparam logic [2:0] SH_OP_LOAD = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        ALU,
        SH_LOAD,
        SH_EXEC,
        SH_CAP,
        MUL,
        RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Request registers; the request kind lives on in the FSM state itself.
    logic [2:0]         fn_q;
    logic [4:0]         shamt_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [CNT_W-1:0]   wait_cnt;

    logic               accept;
    logic [2:0]         fn_d;
    logic [2:0]         alu_sel_d;
    logic [2:0]         shift_op_d;
    logic [5:0]         mult_state_d;
    logic               rsp_load;
    logic [31:0]        rsp_lo_d;
    logic [31:0]        rsp_hi_d;
    logic               rsp_err_d;

`ifndef ALS_SEQ_OVF_TRAP_EN
    // Overflow is deliberately ignored when the trap is compiled out.
    logic unused_ovf;
    assign unused_ovf = alu_overflow;
`endif

    // Shifter is held in reset exactly while the block is.
    assign shift_reset = reset;

    assign oper_a   = a_q;
    assign oper_b   = b_q;
    assign shift_in = a_q;
    assign shift_n  = shamt_q;

    // State register.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, response capture and next values of the control outputs.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        rsp_load     = 1'b0;
        rsp_lo_d     = 32'd0;
        rsp_hi_d     = 32'd0;
        rsp_err_d    = 1'b0;
        fn_d         = fn_q;
        alu_sel_d    = 3'b000;
        shift_op_d   = SH_OP_NOP;
        mult_state_d = 6'd0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    fn_d   = req_fn;
                    case (req_kind)
                        KIND_ALU:   state_nxt = ALU;
                        KIND_SHIFT: state_nxt = SH_LOAD;
                        KIND_MUL:   state_nxt = MUL;
                        default: begin
                            // Illegal kind: answer immediately with an error.
                            state_nxt = RESP;
                            rsp_load  = 1'b1;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            ALU: begin
                state_nxt = RESP;
                rsp_load  = 1'b1;
                rsp_lo_d  = alu_result;
`ifdef ALS_SEQ_OVF_TRAP_EN
                if (alu_overflow) begin
                    rsp_lo_d  = 32'd0;
                    rsp_err_d = 1'b1;
                end
`endif
            end
            SH_LOAD: state_nxt = SH_EXEC;
            SH_EXEC: state_nxt = SH_CAP;
            SH_CAP: begin
                state_nxt = RESP;
                rsp_load  = 1'b1;
                rsp_lo_d  = shift_out;
            end
            MUL: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mult_end) begin
                    state_nxt = RESP;
                    rsp_load  = 1'b1;
                    rsp_lo_d  = mult_prod[31:0];
                    rsp_hi_d  = mult_prod[63:32];
                end else if (wait_cnt == CNT_W'(MULT_TIMEOUT)) begin
                    state_nxt = RESP;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Control outputs are registered, so decode them from the next state.
        case (state_nxt)
            ALU:     alu_sel_d    = fn_d;
            SH_LOAD: shift_op_d   = SH_OP_LOAD;
            SH_EXEC: shift_op_d   = fn_d;
            MUL:     mult_state_d = MULT_STATE;
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk) begin
        if (reset) begin
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_lo     <= 32'd0;
            rsp_hi     <= 32'd0;
            rsp_err    <= 1'b0;
            alu_sel    <= 3'b000;
            shift_op   <= SH_OP_NOP;
            mult_state <= 6'd0;
            wait_cnt   <= '0;
            fn_q       <= 3'b000;
            shamt_q    <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
        end else begin
            req_ready  <= (state_nxt == IDLE);
            busy       <= (state_nxt != IDLE);
            rsp_valid  <= rsp_load;
            alu_sel    <= alu_sel_d;
            shift_op   <= shift_op_d;
            mult_state <= mult_state_d;
            // Counter restarts from zero on every entry into MUL.
            wait_cnt   <= (state == MUL && state_nxt == MUL) ? wait_cnt + CNT_W'(1) : '0;
            if (rsp_load) begin
                rsp_lo  <= rsp_lo_d;
                rsp_hi  <= rsp_hi_d;
                rsp_err <= rsp_err_d;
            end
            if (accept) begin
                fn_q    <= req_fn;
                shamt_q <= req_shamt;
                a_q     <= req_a;
                b_q     <= req_b;
            end
        end
    end

endmodule

// File: tb/tb_als_sequencer.sv
// ---------------------------------------------------------------------------
// tb_als_sequencer
// Directed bench for als_sequencer. Stand-in ALU, shifter and multiplier
// models surround the DUT; each issued request pushes its hand-computed
// response (data, error flag, arrival cycle) into a queue that a separate
// negedge monitor pops whenever rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_als_sequencer;

    localparam logic [5:0]  MS = 6'd1;
    localparam int unsigned MT = 40;

    logic        Clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_fn;
    logic [4:0]  req_shamt;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  alu_sel;
    logic [31:0] oper_a;
    logic [31:0] oper_b;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        shift_reset;
    logic [2:0]  shift_op;
    logic [4:0]  shift_n;
    logic [31:0] shift_in;
    logic [31:0] shift_out;
    logic [5:0]  mult_state;
    logic        mult_end;
    logic [63:0] mult_prod;
    logic        rsp_valid;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic        busy;

    als_sequencer #(.MULT_STATE(MS), .MULT_TIMEOUT(MT)) dut (
        .Clk(Clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_fn(req_fn), .req_shamt(req_shamt),
        .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .oper_a(oper_a), .oper_b(oper_b),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .shift_reset(shift_reset), .shift_op(shift_op), .shift_n(shift_n),
        .shift_in(shift_in), .shift_out(shift_out),
        .mult_state(mult_state), .mult_end(mult_end), .mult_prod(mult_prod),
        .rsp_valid(rsp_valid), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Stand-in ALU.
    logic [31:0] sum;
    always_comb begin
        sum = oper_a + oper_b;
        case (alu_sel)
            3'b000:  alu_result = oper_a & oper_b;
            3'b001:  alu_result = sum;
            3'b010:  alu_result = oper_a - oper_b;
            3'b011:  alu_result = oper_a | oper_b;
            default: alu_result = oper_a ^ oper_b;
        endcase
        alu_overflow = (alu_sel == 3'b001) && (oper_a[31] == oper_b[31]) && (sum[31] != oper_a[31]);
    end

    // Stand-in shifter: load, then shift by shift_n.
    logic [31:0] sh_reg;
    always @(posedge Clk) begin
        if (shift_reset) sh_reg <= 32'd0;
        else begin
            case (shift_op)
                3'b001:  sh_reg <= shift_in;
                3'b010:  sh_reg <= sh_reg << shift_n;
                3'b011:  sh_reg <= sh_reg >> shift_n;
                default: sh_reg <= sh_reg;
            endcase
        end
    end
    assign shift_out = sh_reg;

    // Stand-in multiplier: mult_end in the mult_delay-th MUL cycle when enabled.
    bit mult_en = 1'b0;
    int mult_delay = 0;
    int mcnt = 0;
    always @(posedge Clk) mcnt <= (mult_state == MS) ? mcnt + 1 : 0;
    assign mult_end  = mult_en && (mult_state == MS) && (mcnt == mult_delay - 1);
    assign mult_prod = 64'h0000_0001_FFFF_FFFE;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          due;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge Clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_lo",    64'(rsp_lo),  64'(e.lo));
                chk("rsp_hi",    64'(rsp_hi),  64'(e.hi));
                chk("rsp_err",   64'(rsp_err), 64'(e.err));
                chk("rsp_cycle", 64'(cyc),     64'(e.due));
            end
        end
    end

    // Present a request, wait for acceptance, and queue its expected response
    // lat cycles after the accepting edge. Returns 1 time unit after that edge.
    task automatic issue(input logic [1:0] kind, input logic [2:0] fn, input logic [4:0] shamt,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input logic eerr,
                         input int lat, input bit push);
        int guard = 0;
        exp_t e;
        @(negedge Clk);
        req_kind  = kind;
        req_fn    = fn;
        req_shamt = shamt;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 200) chk("accept_timeout", 64'(req_ready), 64'd1);
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        if (push) begin
            e.lo  = elo;
            e.hi  = ehi;
            e.err = eerr;
            e.due = cyc + lat - 1;
            sbq.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ovf_lo;
        logic        ovf_err;
        int          guard;
`ifdef ALS_SEQ_OVF_TRAP_EN
        ovf_lo  = 32'd0;
        ovf_err = 1'b1;
`else
        ovf_lo  = 32'h8000_0000;
        ovf_err = 1'b0;
`endif
        reset     = 1'b1;
        req_valid = 1'b0;
        req_kind  = 2'b00;
        req_fn    = 3'b000;
        req_shamt = 5'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        chk("rst_rsp_err",     64'(rsp_err),     64'd0);
        chk("rst_rsp_lo",      64'(rsp_lo),      64'd0);
        chk("rst_rsp_hi",      64'(rsp_hi),      64'd0);
        chk("rst_busy",        64'(busy),        64'd0);
        chk("rst_mult_state",  64'(mult_state),  64'd0);
        chk("rst_req_ready",   64'(req_ready),   64'd1);
        chk("rst_shift_reset", 64'(shift_reset), 64'd1);
        chk("rst_alu_sel",     64'(alu_sel),     64'd0);
        chk("rst_shift_op",    64'(shift_op),    64'd0);
        @(negedge Clk);
        reset = 1'b0;
        #1;
        chk("shift_reset_low", 64'(shift_reset), 64'd0);

        // ALU add 5 + 7.
        issue(2'b00, 3'b001, 5'd0, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 2, 1'b1);
        chk("alu_sel_in_alu", 64'(alu_sel), 64'd1);
        chk("alu_busy",       64'(busy),    64'd1);
        repeat (3) @(posedge Clk);

        // Shift 0xF0 left by 4, checking the shift_op sequence.
        issue(2'b01, 3'b010, 5'd4, 32'h0000_00F0, 32'd0, 32'h0000_0F00, 32'd0, 1'b0, 4, 1'b1);
        chk("sh_op_load",  64'(shift_op),  64'd1);
        chk("sh_n",        64'(shift_n),   64'd4);
        chk("sh_in",       64'(shift_in),  64'h0000_00F0);
        chk("sh_ready",    64'(req_ready), 64'd0);
        @(posedge Clk);
        #1;
        chk("sh_op_exec",  64'(shift_op),  64'd2);
        @(posedge Clk);
        #1;
        chk("sh_op_cap",   64'(shift_op),  64'd0);
        repeat (3) @(posedge Clk);

        // Multiply completing in the 33rd MUL cycle.
        mult_en    = 1'b1;
        mult_delay = 33;
        issue(2'b10, 3'b000, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b0, 34, 1'b1);
        chk("mul_state",   64'(mult_state), 64'(MS));
        chk("mul_alu_sel", 64'(alu_sel),    64'd0);
        repeat (38) @(posedge Clk);
        #1;
        chk("mul_hold_lo",    64'(rsp_lo),     64'hFFFF_FFFE);
        chk("mul_hold_hi",    64'(rsp_hi),     64'd1);
        chk("mul_state_idle", 64'(mult_state), 64'd0);
        chk("mul_busy_idle",  64'(busy),       64'd0);

        // Multiply timeout.
        mult_en = 1'b0;
        issue(2'b10, 3'b000, 5'd0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, int'(MT) + 2, 1'b1);
        repeat (MT + 5) @(posedge Clk);

        // Illegal kind, then a request held during RESP.
        issue(2'b11, 3'b000, 5'd0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 1, 1'b1);
        chk("resp_ready", 64'(req_ready), 64'd0);
        chk("resp_busy",  64'(busy),      64'd1);
        issue(2'b00, 3'b010, 5'd0, 32'd100, 32'd58, 32'd42, 32'd0, 1'b0, 2, 1'b1);
        repeat (3) @(posedge Clk);

        // Signed overflow on add.
        issue(2'b00, 3'b001, 5'd0, 32'h7FFF_FFFF, 32'd1, ovf_lo, 32'd0, ovf_err, 2, 1'b1);
        repeat (3) @(posedge Clk);

        // Reset during the 10th MUL cycle aborts silently.
        mult_en = 1'b0;
        issue(2'b10, 3'b000, 5'd0, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        chk("abort_mul_state_before", 64'(mult_state), 64'(MS));
        reset = 1'b1;
        #1;
        chk("abort_shift_reset", 64'(shift_reset), 64'd1);
        @(posedge Clk);
        #1;
        chk("abort_mult_state", 64'(mult_state), 64'd0);
        chk("abort_busy",       64'(busy),       64'd0);
        chk("abort_rsp_valid",  64'(rsp_valid),  64'd0);
        @(negedge Clk);
        reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("abort_ready", 64'(req_ready), 64'd1);

        // Recovery: ALU OR after the abort.
        issue(2'b00, 3'b011, 5'd0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 32'd0, 1'b0, 2, 1'b1);

        guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(posedge Clk);
            guard++;
        end
        repeat (2) @(posedge Clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
